// File: rtl/dpll_pkg.sv
// -----------------------------------------------------------------------------
// dpll_pkg
//   Shared definitions for the DPLL acquisition / lock controller:
//   - dpll_state_t : controller state (IDLE, ACQ, MEAS, LOCKED)
//   - default widths and thresholds used as parameter defaults by the top
//   - DPLL_TIMEOUT : all-ones period-counter value that marks a lost reference
//
//   Optional feature macro used by the top: DPLL_CTRL_AVG_EN
// -----------------------------------------------------------------------------
package dpll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } dpll_state_t;

  localparam int DPLL_W          = 16;
  localparam int DPLL_LOCK_TOL   = 2;
  localparam int DPLL_LOCK_CNT   = 4;
  localparam int DPLL_MIN_PERIOD = 8;

  // Period counter value at which the reference is declared missing.
  localparam logic [DPLL_W-1:0] DPLL_TIMEOUT = '1;

endpackage

// File: rtl/dpll_edge_sync.sv
// -----------------------------------------------------------------------------
// dpll_edge_sync
//   Brings the asynchronous reference into the clock domain with a 2-flop
//   synchronizer, then registers a one-cycle pulse for each synchronized
//   rising edge. The pulse is high 3 clocks after the input rise is first
//   sampled.
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   din    in   asynchronous input
//   pulse  out  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module dpll_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sr[0], sr[1]: synchronizer; sr[2]: previous synchronized value.
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], din};
      pulse <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/dpll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// dpll_lock_ctrl
//   Acquisition and lock controller for the DPLL frequency divider. Measures
//   the period of reference fin in dco_clk cycles, publishes it as fin_w,
//   tracks measurement stability to drive locked, and flags missing or too
//   short reference periods.
//
//   Optional feature: define DPLL_CTRL_AVG_EN to smooth fin_w as
//   (fin_w + meas) >> 1; the first valid measurement after acquisition is
//   loaded directly. Default build loads fin_w = meas on every update.
//
// Handshake/pulse semantics: fin_w_vld is a one-cycle strobe marking the
//   cycle in which fin_w takes a new value; meas_err is a one-cycle strobe
//   for a timeout or short period. There is no back-pressure; the two
//   strobes are never high together and neither is issued while en is low.
//
// Ports:
//   dco_clk    in   sole clock
//   rst_n      in   synchronous active-low reset
//   en         in   enable; low forces IDLE
//   fin        in   asynchronous reference
//   fin_w      out  frequency word (dco_clk cycles per fin period)
//   fin_w_vld  out  one-cycle pulse on each fin_w update
//   locked     out  high while in LOCKED
//   meas_err   out  one-cycle pulse on timeout or short period
//   dbg_state  out  current controller state (dpll_state_t encoding)
// -----------------------------------------------------------------------------
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int W          = DPLL_W,
  parameter int LOCK_TOL   = DPLL_LOCK_TOL,
  parameter int LOCK_CNT   = DPLL_LOCK_CNT,
  parameter int MIN_PERIOD = DPLL_MIN_PERIOD
) (
  input  logic         dco_clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         fin,
  output logic [W-1:0] fin_w,
  output logic         fin_w_vld,
  output logic         locked,
  output logic         meas_err,
  output logic [1:0]   dbg_state
);

  localparam int             MCW      = $clog2(LOCK_CNT + 1);
  localparam logic [W:0]     TOL      = (W+1)'(LOCK_TOL);
  localparam logic [W-1:0]   MINP     = W'(MIN_PERIOD);
  localparam logic [W-1:0]   TIMEOUT  = '1;
  localparam logic [MCW-1:0] LOCK_TGT = MCW'(LOCK_CNT);

  dpll_state_t    state, state_nxt;
  logic           fin_edge;
  logic [W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]   meas;
  logic [W-1:0]   upd_val, fin_w_nxt;
  logic [MCW-1:0] match_cnt, match_nxt;
  logic [W:0]     diff, abs_diff;
  logic           tracking, timeout, short_p, is_match, lock_hit;
  logic           err, upd;

  dpll_edge_sync u_sync (
    .clk   (dco_clk),
    .rst_n (rst_n),
    .din   (fin),
    .pulse (fin_edge)
  );

  // ---------------------------------------------------------------------------
  // Measurement evaluation
  // ---------------------------------------------------------------------------
  // cnt is cleared in the edge cycle, so the interval between edges is cnt+1.
  assign meas     = cnt + W'(1);
  assign tracking = (state == MEAS) || (state == LOCKED);
  assign timeout  = (cnt == TIMEOUT);
  assign short_p  = (meas < MINP);

  // Difference at W+1 bits so a full-range meas or fin_w cannot wrap.
  assign diff     = {1'b0, meas} - {1'b0, fin_w};
  assign abs_diff = diff[W] ? (~diff + (W+1)'(1)) : diff;
  assign is_match = (abs_diff <= TOL);
  assign lock_hit = ((match_cnt + MCW'(1)) == LOCK_TGT);

  // Timeout wins over a coincident edge: that edge is not evaluated.
  assign err = en && tracking && (timeout || (fin_edge && short_p));
  assign upd = en && tracking && fin_edge && !timeout && !short_p;

`ifdef DPLL_CTRL_AVG_EN
  logic       first_upd;
  logic [W:0] avg_sum;

  assign avg_sum = {1'b0, fin_w} + {1'b0, meas};
  assign upd_val = first_upd ? meas : W'(avg_sum >> 1);

  // Set whenever the controller (re)enters ACQ so that the first valid
  // measurement afterwards replaces the stale word instead of averaging.
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      first_upd <= 1'b0;
    end else if (state_nxt == ACQ) begin
      first_upd <= 1'b1;
    end else if (upd) begin
      first_upd <= 1'b0;
    end
  end
`else
  assign upd_val = meas;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:   state_nxt = ACQ;
        ACQ:    if (fin_edge) state_nxt = MEAS;
        MEAS: begin
          if (err)                            state_nxt = ACQ;
          else if (upd && is_match && lock_hit) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (err)                 state_nxt = ACQ;
          else if (upd && !is_match) state_nxt = MEAS;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // Counter runs only while the next state measures; the edge restarts it
    // and any drop to IDLE/ACQ parks it at zero (this also absorbs the wrap
    // on timeout).
    cnt_nxt = '0;
    if (((state_nxt == MEAS) || (state_nxt == LOCKED)) && !fin_edge) begin
      cnt_nxt = cnt + W'(1);
    end

    match_nxt = match_cnt;
    if ((state_nxt == IDLE) || (state_nxt == ACQ)) begin
      match_nxt = '0;
    end else if (upd) begin
      if (!is_match) begin
        match_nxt = '0;
      end else if (state == MEAS) begin
        match_nxt = match_cnt + MCW'(1);
      end
    end

    fin_w_nxt = upd ? upd_val : fin_w;
  end

  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      match_cnt <= '0;
      fin_w     <= '0;
      fin_w_vld <= 1'b0;
      meas_err  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      match_cnt <= match_nxt;
      fin_w     <= fin_w_nxt;
      fin_w_vld <= upd;
      meas_err  <= err;
    end
  end

  assign locked    = (state == LOCKED);
  assign dbg_state = state;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpll_lock_ctrl
//   Self-checking bench for dpll_lock_ctrl: directed vector table, hand-written
//   timeout / enable / reset sequences, and randomized reference periods
//   checked every cycle against a period-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_dpll_lock_ctrl;
  import dpll_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        dco_clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fin;
  logic [15:0] fin_w;
  logic        fin_w_vld;
  logic        locked;
  logic        meas_err;
  logic [1:0]  dbg_state;

  always #5 dco_clk = ~dco_clk;

  dpll_lock_ctrl dut (
    .dco_clk   (dco_clk),
    .rst_n     (rst_n),
    .en        (en),
    .fin       (fin),
    .fin_w     (fin_w),
    .fin_w_vld (fin_w_vld),
    .locked    (locked),
    .meas_err  (meas_err),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_fail = 0;
  bit chk_on   = 1'b0;
  int vld_cnt  = 0;
  int err_cnt  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: works on absolute cycle numbers. A measurement is the
  // number of clocks between two accepted edges; the edge is seen 3 clocks
  // after fin is sampled high (plus the register stage that acts on it).
  // ---------------------------------------------------------------------------
  int unsigned cyc    = 0;
  int unsigned m_last = 0;
  logic        h1 = 0, h2 = 0, h3 = 0, h4 = 0;
  dpll_state_t m_state = IDLE;
  int          m_fin_w = 0;
  int          m_mc    = 0;
  bit          m_first = 1'b0;
  bit          m_vld   = 1'b0;
  bit          m_err   = 1'b0;

  always @(posedge dco_clk) begin
    bit e;
    int el;
    int d;
    bit match;
    cyc++;
    e = h3 & ~h4;
    {h4, h3, h2, h1} = {h3, h2, h1, fin};
    m_vld = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      {h4, h3, h2, h1} = 4'b0;
      m_state = IDLE;
      m_fin_w = 0;
      m_mc    = 0;
      m_first = 1'b0;
    end else if (!en) begin
      m_state = IDLE;
    end else if (m_state == IDLE) begin
      m_state = ACQ;
      m_first = 1'b1;
    end else if (m_state == ACQ) begin
      if (e) begin
        m_state = MEAS;
        m_last  = cyc;
      end
    end else begin
      el = int'(cyc - m_last);
      if (el == 65536) begin
        m_err = 1'b1; m_state = ACQ; m_mc = 0; m_first = 1'b1;
      end else if (e) begin
        m_last = cyc;
        if (el < 8) begin
          m_err = 1'b1; m_state = ACQ; m_mc = 0; m_first = 1'b1;
        end else begin
          d = el - m_fin_w;
          if (d < 0) d = -d;
          match = (d <= 2);
`ifdef DPLL_CTRL_AVG_EN
          m_fin_w = m_first ? el : (m_fin_w + el) / 2;
`else
          m_fin_w = el;
`endif
          m_first = 1'b0;
          m_vld   = 1'b1;
          if (m_state == MEAS) begin
            m_mc = match ? m_mc + 1 : 0;
            if (m_mc == 4) m_state = LOCKED;
          end else if (!match) begin
            m_state = MEAS;
            m_mc    = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge dco_clk) begin
    if (chk_on && mdl_fail < 50) begin
      n_checks++;
      if (fin_w !== 16'(m_fin_w) || fin_w_vld !== m_vld || meas_err !== m_err ||
          locked !== (m_state == LOCKED) || dbg_state !== 2'(m_state)) begin
        n_fail++;
        mdl_fail++;
        $display("FAIL model_cycle t=%0t actual fin_w=%0d vld=%0b err=%0b locked=%0b st=%0d expected fin_w=%0d vld=%0b err=%0b locked=%0b st=%0d",
                 $time, fin_w, fin_w_vld, meas_err, locked, dbg_state,
                 m_fin_w, m_vld, m_err, (m_state == LOCKED), 2'(m_state));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge dco_clk);
      vld_cnt += int'(fin_w_vld);
      err_cnt += int'(meas_err);
    end
  endtask

  // n reference periods of p clocks each; every period starts with a rise.
  task automatic send(input int p, input int n);
    repeat (n) begin
      fin = 1'b1;
      wait_cyc(2);
      fin = 1'b0;
      wait_cyc(p - 2);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          period;
    int          n;
    int          exp_fin_w;
    int          exp_locked;
    dpll_state_t exp_state;
    int          exp_vld;
    int          exp_err;
  } vec_t;

  vec_t tbl[16];

`ifdef DPLL_CTRL_AVG_EN
  localparam int STEP_W = 105;
  localparam int MIN8_W = 54;
`else
  localparam int STEP_W = 110;
  localparam int MIN8_W = 8;
`endif

  task automatic run_row(input int i);
    vld_cnt = 0;
    err_cnt = 0;
    send(tbl[i].period, tbl[i].n);
    chk($sformatf("row%0d_fin_w", i),  int'(fin_w),     tbl[i].exp_fin_w);
    chk($sformatf("row%0d_locked", i), int'(locked),    tbl[i].exp_locked);
    chk($sformatf("row%0d_state", i),  int'(dbg_state), int'(tbl[i].exp_state));
    chk($sformatf("row%0d_vld", i),    vld_cnt,         tbl[i].exp_vld);
    chk($sformatf("row%0d_err", i),    err_cnt,         tbl[i].exp_err);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int p;
    tbl[0]  = '{100, 1, 0,      0, MEAS,   0, 0};  // first edge: no output
    tbl[1]  = '{100, 1, 100,    0, MEAS,   1, 0};  // fin_w = 100
    tbl[2]  = '{100, 3, 100,    0, MEAS,   3, 0};  // matches 1..3
    tbl[3]  = '{110, 1, 100,    1, LOCKED, 1, 0};  // 4th match -> locked
    tbl[4]  = '{100, 1, STEP_W, 0, MEAS,   1, 0};  // step to 110 unlocks
    tbl[5]  = '{100, 4, 100,    0, MEAS,   4, 0};
    tbl[6]  = '{100, 1, 100,    1, LOCKED, 1, 0};
    tbl[7]  = '{100, 1, 100,    0, MEAS,   0, 0};  // after timeout: reacquire
    tbl[8]  = '{5,   1, 100,    0, MEAS,   1, 0};
    tbl[9]  = '{100, 1, 100,    0, ACQ,    0, 1};  // period 5 rejected
    tbl[10] = '{100, 1, 100,    0, MEAS,   0, 0};
    tbl[11] = '{8,   1, 100,    0, MEAS,   1, 0};
    tbl[12] = '{7,   1, MIN8_W, 0, MEAS,   1, 0};  // meas 8 accepted
    tbl[13] = '{100, 1, MIN8_W, 0, ACQ,    0, 1};  // meas 7 rejected
    tbl[14] = '{100, 1, MIN8_W, 0, MEAS,   0, 0};
    tbl[15] = '{100, 1, 100,    0, MEAS,   1, 0};  // direct load after ACQ

    rst_n = 1'b0;
    en    = 1'b0;
    fin   = 1'b0;
    @(negedge dco_clk);
    chk_on = 1'b1;

    // Reset held with fin toggling.
    vld_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      fin = ~fin;
      wait_cyc(1);
    end
    chk("rst_fin_w",  int'(fin_w),     0);
    chk("rst_locked", int'(locked),    0);
    chk("rst_state",  int'(dbg_state), int'(IDLE));
    chk("rst_pulses", vld_cnt + err_cnt, 0);

    rst_n = 1'b1;
    fin   = 1'b0;
    wait_cyc(4);
    en = 1'b1;
    wait_cyc(2);
    chk("en_to_acq", int'(dbg_state), int'(ACQ));

    for (int i = 0; i <= 6; i++) run_row(i);

    // Reference lost while locked: timeout when cnt reaches all-ones.
    vld_cnt = 0;
    err_cnt = 0;
    k = 0;
    while (err_cnt == 0 && k < 70000) begin
      wait_cyc(1);
      k++;
    end
    chk("timeout_seen",   err_cnt, 1);
    chk("timeout_cycles", k, int'(DPLL_TIMEOUT) + 1 - 96);
    chk("timeout_fin_w",  int'(fin_w), 100);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_state",  int'(dbg_state), int'(ACQ));
    chk("timeout_vld",    vld_cnt, 0);

    for (int i = 7; i <= 15; i++) run_row(i);

    // Enable dropped mid-measurement.
    wait_cyc(10);
    en = 1'b0;
    vld_cnt = 0;
    err_cnt = 0;
    wait_cyc(1);
    chk("endrop_state",  int'(dbg_state), int'(IDLE));
    chk("endrop_locked", int'(locked), 0);
    send(50, 6);
    chk("endrop_pulses", vld_cnt + err_cnt, 0);
    chk("endrop_fin_w",  int'(fin_w), 100);
    chk("endrop_idle",   int'(dbg_state), int'(IDLE));

    en = 1'b1;
    vld_cnt = 0;
    err_cnt = 0;
    send(100, 3);
    chk("reen_vld",   vld_cnt, 2);
    chk("reen_err",   err_cnt, 0);
    chk("reen_state", int'(dbg_state), int'(MEAS));

    // Reset mid-measurement.
    wait_cyc(20);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("midrst_fin_w", int'(fin_w), 0);
    chk("midrst_flags", int'({fin_w_vld, meas_err, locked}), 0);
    chk("midrst_state", int'(dbg_state), int'(IDLE));
    rst_n = 1'b1;

    // Randomized periods, with repeats to reach lock and short periods near
    // the minimum, occasionally interrupted by an enable drop.
    for (int b = 0; b < 25; b++) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(20, 200);
      for (int r = 0; r < $urandom_range(1, 6); r++) begin
        send(p + $urandom_range(0, 2), 1);
      end
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        wait_cyc($urandom_range(1, 10));
        en = 1'b1;
      end
    end

    wait_cyc(10);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #1200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
